// File: rtl/fetch_pkg.sv
// Types and constants shared between the fetch and decode stages:
// FSM encoding, the canonical NOP, and the IF/DE pipeline register layout.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            err;
  } if_de_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: PC register, inst_mem address, and IF/DE
// register offered to decode over valid/ready, with redirect, halt and range flag.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     REG_SIZE       = 32,
  parameter int unsigned     MEM_SIZE_IN_KB = 1,
  parameter logic [31:0]     RESET_PC       = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic [REG_SIZE-1:0] addr_o,
  input  logic [REG_SIZE-1:0] inst_i,
  input  logic                redirect_i,
  input  logic [REG_SIZE-1:0] redirect_pc_i,
  input  logic                halt_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [REG_SIZE-1:0] out_inst_o,
  output logic [REG_SIZE-1:0] out_pc_o,
  output logic                out_err_o,
  output logic                misalign_o
);

  localparam logic [REG_SIZE-1:0] MEM_BYTES = REG_SIZE'(MEM_SIZE_IN_KB * 1024);
  localparam logic [REG_SIZE-1:0] PC_STEP   = REG_SIZE'(4);

  localparam if_de_t IF_DE_RESET = '{inst: NOP_INST, pc: '0, err: 1'b0};

  fetch_state_e        state_q, state_d;
  logic [REG_SIZE-1:0] pc_q, pc_d;
  if_de_t              if_de_q, if_de_d;
  logic                valid_q, valid_d;
  logic                misalign_q, misalign_d;
  logic                fire;
  logic                out_of_range;

  // Next-state, PC and IF/DE register update; redirect outranks everything.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_de_d      = if_de_q;
    valid_d      = valid_q;
    misalign_d   = 1'b0;
    out_of_range = (pc_q >= MEM_BYTES);
    fire         = (state_q == RUN) && !halt_i && !redirect_i
                   && (!valid_q || out_ready_i);

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_i && !redirect_i) state_d = HALT;
               else                       state_d = RUN;
      HALT:    if (redirect_i) state_d = RUN;
               else            state_d = HALT;
      default: state_d = BOOT;
    endcase

    if (redirect_i) begin
      pc_d       = word_align(redirect_pc_i);
      valid_d    = 1'b0;
      misalign_d = |redirect_pc_i[1:0];
    end else if (fire) begin
      if_de_d.inst = out_of_range ? NOP_INST : inst_i;
      if_de_d.pc   = pc_q;
      if_de_d.err  = out_of_range;
      valid_d      = 1'b1;
      pc_d         = pc_q + PC_STEP;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, PC and IF/DE registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_de_q    <= IF_DE_RESET;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_de_q    <= if_de_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign addr_o      = pc_q;
  assign out_valid_o = valid_q;
  assign out_inst_o  = if_de_q.inst;
  assign out_pc_o    = if_de_q.pc;
  assign out_err_o   = if_de_q.err;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through fetch, stall, redirect, halt and
// range cases, then random traffic against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] MEM_TOP  = 32'h0000_0400;
  localparam int          M_BOOT   = 0;
  localparam int          M_RUN    = 1;
  localparam int          M_HALT   = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] addr_o;
  logic [31:0] inst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_inst_o;
  logic [31:0] out_pc_o;
  logic        out_err_o;
  logic        misalign_o;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what decode should be seeing, plus where fetch goes next.
  int          m_mode;
  logic [31:0] m_next_pc;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic        m_err;
  logic        m_mis;

  fetch_unit #(
    .REG_SIZE(32), .MEM_SIZE_IN_KB(1), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .addr_o(addr_o), .inst_i(inst_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_inst_o(out_inst_o), .out_pc_o(out_pc_o), .out_err_o(out_err_o),
    .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  assign inst_i = mem[addr_o[9:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_next_pc = 32'h0; m_valid = 1'b0;
    m_inst = NOP; m_pc = 32'h0; m_err = 1'b0; m_mis = 1'b0;
  endtask

  task automatic check_model();
    check("addr", addr_o, m_next_pc);
    check("valid", {31'd0, out_valid_o}, {31'd0, m_valid});
    check("out_pc", out_pc_o, m_pc);
    check("out_inst", out_inst_o, m_inst);
    check("out_err", {31'd0, out_err_o}, {31'd0, m_err});
    check("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, addr_o, 32'h0);
    check({tag, "_valid"}, {31'd0, out_valid_o}, 32'd0);
    check({tag, "_inst"}, out_inst_o, NOP);
    check({tag, "_pc"}, out_pc_o, 32'h0);
    check({tag, "_err"}, {31'd0, out_err_o}, 32'd0);
    check({tag, "_mis"}, {31'd0, misalign_o}, 32'd0);
  endtask

  // One clock: apply inputs, advance the model by the transaction rules, compare.
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc, input logic hlt);
    bit handed_over;
    out_ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc; halt_i = hlt;
    handed_over = m_valid && rdy;
    if (rd) begin
      m_next_pc = rpc & 32'hFFFF_FFFC;
      m_valid   = 1'b0;
      m_mis     = (rpc[1:0] != 2'b00);
      m_mode    = M_RUN;
    end else begin
      m_mis = 1'b0;
      if (m_mode == M_RUN && !hlt && (!m_valid || handed_over)) begin
        m_pc      = m_next_pc;
        m_err     = (m_next_pc >= MEM_TOP);
        m_inst    = m_err ? NOP : mem[m_next_pc[9:2]];
        m_valid   = 1'b1;
        m_next_pc = m_next_pc + 32'd4;
      end else if (handed_over) begin
        m_valid = 1'b0;
      end
      if (m_mode == M_BOOT) m_mode = M_RUN;
      else if (m_mode == M_RUN && hlt) m_mode = M_HALT;
    end
    @(posedge clk_i);
    #1;
    check_model();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;

    rst_ni = 1'b0; out_ready_i = 1'b1; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; halt_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_values("reset");
    rst_ni = 1'b1;

    // First valid at edge 2, then one per cycle.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("boot_no_valid", {31'd0, out_valid_o}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("first_pc", out_pc_o, 32'h0);
    check("first_inst", out_inst_o, 32'h11);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("second_inst", out_inst_o, 32'h22);

    // Stall three cycles at pc 4.
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("stall_pc", out_pc_o, 32'h4);
    check("stall_addr", addr_o, 32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("resume_inst", out_inst_o, 32'h33);

    // Redirect while stalled flushes the held entry.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b0);
    check("flush_valid", {31'd0, out_valid_o}, 32'd0);
    check("redir_addr", addr_o, 32'h40);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("redir_pc", out_pc_o, 32'h40);

    // Misaligned target with a simultaneous halt: redirect wins.
    step(1'b1, 1'b1, 32'h42, 1'b1);
    check("mis_addr", addr_o, 32'h40);
    check("mis_pulse", {31'd0, misalign_o}, 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("mis_drop", {31'd0, misalign_o}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);

    // Halt: drain, then ignore everything but redirect.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    check("halt_drained", {31'd0, out_valid_o}, 32'd0);
    step(1'b1, 1'b1, 32'h10, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("halt_resume_pc", out_pc_o, 32'h10);

    // Upper edge of instruction memory.
    step(1'b1, 1'b1, 32'h3FC, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("last_word_err", {31'd0, out_err_o}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("oob_pc", out_pc_o, 32'h400);
    check("oob_err", {31'd0, out_err_o}, 32'd1);
    check("oob_inst", out_inst_o, NOP);

    // PC wraps past the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("wrap_addr", addr_o, 32'h0);

    // Asynchronous reset mid-cycle while stalled.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    out_ready_i = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        rdy, rd, hlt;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      hlt = ($urandom_range(0, 29) == 0);
      tgt = $urandom_range(0, 32'h47F);
      step(rdy, rd, tgt, hlt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
